pulse_seq_ctrl: RTL and testbench

PULSE_SEQ_CTRL -- requirements
Module: pulse_seq_ctrl

---
 rtl/pulse_seq_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pulse_seq_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_seq_ctrl.sv
// CPMG pulse-train sequencer: 90° pulse, tau wait, then echo_num repetitions of
// a 180° pulse followed by a 2*tau acquisition window, driving a bridge-pulse stage.
module pulse_seq_ctrl #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_data,
    input  logic        seq_start,
    input  logic        seq_abort,
    input  logic        bri_cycle,
    output logic        pluse_load,
    output logic        state_start,
    output logic        phase,
    output logic [7:0]  bri_para,
    output logic [15:0] qq_para,
    output logic        echo_win,
    output logic [15:0] echo_cnt,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, FIRE, PULSE, TAU, ACQ, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] tau_q, echo_num_q, qq_q;
    logic [7:0]  p90_q, p180_q;
    logic        phase_q, phase_d;
    logic [7:0]  bri_para_q, bri_para_d;
    logic [15:0] qq_para_q, qq_para_d;
    logic [15:0] echo_cnt_q, echo_cnt_d;
    logic        err_q, err_d;
    logic [16:0] tmr_q, tmr_d;
    logic [7:0]  bcnt_q, bcnt_d;
    logic [TW-1:0] to_q, to_d;
    logic [8:0]  bri_tgt;
    logic [15:0] echo_nxt;

    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign done        = (state_q == DONE);
    assign pluse_load  = (state_q == LOAD);
    assign state_start = (state_q == FIRE);
    assign echo_win    = (state_q == ACQ);
    assign phase       = phase_q;
    assign bri_para    = bri_para_q;
    assign qq_para     = qq_para_q;
    assign echo_cnt    = echo_cnt_q;
    assign err         = err_q;

    // A zero-length pulse still waits for one bridge cycle.
    assign bri_tgt  = (bri_para_q == 8'd0) ? 9'd1 : {1'b0, bri_para_q};
    assign echo_nxt = echo_cnt_q + 16'd1;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            tau_q      <= 16'd100;
            echo_num_q <= 16'd0;
            p90_q      <= 8'd4;
            p180_q     <= 8'd8;
            qq_q       <= 16'd0;
        end else if (cfg_we && !busy) begin
            case (cfg_addr)
                2'd0: tau_q      <= cfg_data;
                2'd1: echo_num_q <= cfg_data;
                2'd2: {p180_q, p90_q} <= cfg_data;
                default: qq_q    <= cfg_data;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bri_para_d = bri_para_q;
        qq_para_d  = qq_para_q;
        echo_cnt_d = echo_cnt_q;
        err_d      = err_q;
        tmr_d      = tmr_q;
        bcnt_d     = bcnt_q;
        to_d       = to_q;
        case (state_q)
            IDLE: if (seq_start && echo_num_q != 16'd0 && tau_q >= 16'd2) begin
                state_d    = LOAD;
                echo_cnt_d = 16'd0;
                err_d      = 1'b0;
                phase_d    = 1'b0;
                bri_para_d = p90_q;
                qq_para_d  = qq_q;
            end
            LOAD: state_d = FIRE;
            FIRE: begin
                state_d = PULSE;
                bcnt_d  = 8'd0;
                to_d    = TW'(1);
            end
            PULSE: begin
                if (bri_cycle) begin
                    to_d = TW'(1);
                    if ({1'b0, bcnt_q} + 9'd1 >= bri_tgt) begin
                        state_d = phase_q ? ACQ : TAU;
                        tmr_d   = 17'd1;
                    end else begin
                        bcnt_d = bcnt_q + 8'd1;
                    end
                end else if (to_q >= TW'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            TAU: begin
                if (tmr_q >= {1'b0, tau_q}) begin
                    state_d    = LOAD;
                    phase_d    = 1'b1;
                    bri_para_d = p180_q;
                    qq_para_d  = qq_q;
                end else begin
                    tmr_d = tmr_q + 17'd1;
                end
            end
            ACQ: begin
                if (tmr_q >= {tau_q, 1'b0}) begin
                    echo_cnt_d = echo_nxt;
                    if (echo_nxt == echo_num_q) begin
                        state_d = DONE;
                    end else begin
                        state_d    = LOAD;
                        phase_d    = 1'b1;
                        bri_para_d = p180_q;
                        qq_para_d  = qq_q;
                    end
                end else begin
                    tmr_d = tmr_q + 17'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort wins over start, completion, timeout and register loads.
        if (seq_abort) begin
            state_d    = IDLE;
            phase_d    = phase_q;
            bri_para_d = bri_para_q;
            qq_para_d  = qq_para_q;
            echo_cnt_d = echo_cnt_q;
            err_d      = err_q;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= 1'b0;
            bri_para_q <= 8'd0;
            qq_para_q  <= 16'd0;
            echo_cnt_q <= 16'd0;
            err_q      <= 1'b0;
            tmr_q      <= 17'd0;
            bcnt_q     <= 8'd0;
            to_q       <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bri_para_q <= bri_para_d;
            qq_para_q  <= qq_para_d;
            echo_cnt_q <= echo_cnt_d;
            err_q      <= err_d;
            tmr_q      <= tmr_d;
            bcnt_q     <= bcnt_d;
            to_q       <= to_d;
        end
    end

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Scoreboard bench for pulse_seq_ctrl: expected loads, tau gaps and echo windows
// are queued when a train is started and checked as the DUT produces them.
module tb_pulse_seq_ctrl;
    localparam int TO = 64;

    logic        clk_sys = 1'b0, rst = 1'b1, cfg_we = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [15:0] cfg_data = 16'd0;
    logic        seq_start = 1'b0, seq_abort = 1'b0, bri_cycle = 1'b0;
    logic        pluse_load, state_start, phase, echo_win, busy, done, err;
    logic [7:0]  bri_para;
    logic [15:0] qq_para, echo_cnt;

    pulse_seq_ctrl #(.TIMEOUT(TO)) dut (
        .clk_sys(clk_sys), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .seq_start(seq_start), .seq_abort(seq_abort),
        .bri_cycle(bri_cycle), .pluse_load(pluse_load), .state_start(state_start),
        .phase(phase), .bri_para(bri_para), .qq_para(qq_para), .echo_win(echo_win),
        .echo_cnt(echo_cnt), .busy(busy), .done(done), .err(err)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk = 0, n_err = 0;
    int cyc = 0, done_cnt = 0, last_bri = 0, fire_cyc = 0, wlen = 0;
    logic prev_phase = 1'b1;
    bit   bri_en = 1'b1;
    logic [24:0] e;
    logic [24:0] exp_load[$];
    int          exp_gap[$];
    int          exp_win[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys); #1;
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [15:0] d);
        tick(); cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick(); cfg_we = 1'b0;
    endtask

    task automatic start_seq();
        tick(); seq_start = 1'b1;
        tick(); seq_start = 1'b0;
    endtask

    // One 90° load, then n 180° loads; one tau gap; n windows of 2*tau.
    task automatic push_train(input int tau, input int n, input logic [7:0] p90,
                              input logic [7:0] p180, input logic [15:0] qq);
        exp_load.push_back({1'b0, p90, qq});
        for (int i = 0; i < n; i++) exp_load.push_back({1'b1, p180, qq});
        exp_gap.push_back(tau + 1);
        for (int i = 0; i < n; i++) exp_win.push_back(2 * tau);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_sys);
            if (done) break;
        end
        chk("done_reached", done, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_load"}, pluse_load, 0);  chk({tag, "_start"}, state_start, 0);
        chk({tag, "_phase"}, phase, 0);      chk({tag, "_bri"}, bri_para, 0);
        chk({tag, "_qq"}, qq_para, 0);       chk({tag, "_win"}, echo_win, 0);
        chk({tag, "_ecnt"}, echo_cnt, 0);    chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);        chk({tag, "_err"}, err, 0);
    endtask

    always @(posedge clk_sys) cyc++;

    always @(negedge clk_sys) begin
        if (!rst) begin
            if (bri_cycle) last_bri = cyc;
            if (state_start) fire_cyc = cyc;
            if (done) done_cnt++;
            if (pluse_load) begin
                if (exp_load.size() == 0) chk("load_unexpected", 1, 0);
                else begin
                    e = exp_load.pop_front();
                    chk("load_phase", phase, e[24]);
                    chk("load_bri", bri_para, e[23:16]);
                    chk("load_qq", qq_para, e[15:0]);
                end
                if (phase && !prev_phase) begin
                    if (exp_gap.size() == 0) chk("gap_unexpected", 1, 0);
                    else chk("tau_gap", cyc - last_bri, exp_gap.pop_front());
                end
                prev_phase = phase;
            end
            if (echo_win) wlen++;
            else if (wlen > 0) begin
                if (exp_win.size() == 0) chk("win_unexpected", 1, 0);
                else chk("win_len", wlen, exp_win.pop_front());
                wlen = 0;
            end
        end
    end

    // Bridge-pulse stage model: one strobe every 5 cycles, bri_para strobes per pulse.
    initial begin : bridge
        int n;
        forever begin
            @(negedge clk_sys);
            if (state_start && bri_en) begin
                n = (bri_para == 8'd0) ? 1 : int'(bri_para);
                for (int i = 0; i < n; i++) begin
                    repeat (4) @(posedge clk_sys);
                    #1 bri_cycle = 1'b1;
                    @(posedge clk_sys);
                    #1 bri_cycle = 1'b0;
                end
            end
        end
    end

    initial begin : main
        int d0, nr;
        logic pw;
        repeat (3) @(posedge clk_sys);
        #1 rst = 1'b0;
        @(negedge clk_sys);
        chk_all_zero("rst");

        // Start is refused with echo_num=0, then with tau=1.
        start_seq(); @(negedge clk_sys); chk("s2_busy_num0", busy, 0);
        cfg_wr(2'd1, 16'd3); cfg_wr(2'd0, 16'd1);
        start_seq(); @(negedge clk_sys); chk("s2_busy_tau1", busy, 0);
        repeat (5) @(negedge clk_sys);

        // Full train, with a tau write while busy that must not take effect.
        cfg_wr(2'd0, 16'd10); cfg_wr(2'd2, 16'h0402); cfg_wr(2'd3, 16'h1234);
        push_train(10, 3, 8'd2, 8'd4, 16'h1234);
        d0 = done_cnt;
        start_seq(); @(negedge clk_sys);
        chk("s1_busy", busy, 1); chk("s1_ecnt0", echo_cnt, 0);
        repeat (15) tick();
        cfg_wr(2'd0, 16'd50);
        wait_done(2000);
        chk("s1_ecnt", echo_cnt, 3);
        repeat (5) @(negedge clk_sys);
        chk("s1_busy_end", busy, 0); chk("s1_ecnt_hold", echo_cnt, 3);
        chk("s1_done_once", done_cnt - d0, 1);

        // Idle write of tau=50 applies; zero-length 90° pulse behaves as length 1.
        cfg_wr(2'd0, 16'd50); cfg_wr(2'd1, 16'd1); cfg_wr(2'd2, 16'h0400);
        push_train(50, 1, 8'd0, 8'd4, 16'h1234);
        start_seq();
        wait_done(2000);
        chk("s5_ecnt", echo_cnt, 1);
        repeat (3) @(negedge clk_sys);

        // Abort in the second acquisition window, 6 cycles in.
        cfg_wr(2'd0, 16'd10); cfg_wr(2'd1, 16'd3); cfg_wr(2'd2, 16'h0402);
        exp_load.push_back({1'b0, 8'd2, 16'h1234});
        exp_load.push_back({1'b1, 8'd4, 16'h1234});
        exp_load.push_back({1'b1, 8'd4, 16'h1234});
        exp_gap.push_back(11);
        exp_win.push_back(20); exp_win.push_back(6);
        d0 = done_cnt; nr = 0; pw = 1'b0;
        start_seq();
        for (int i = 0; i < 1000 && nr < 2; i++) begin
            @(negedge clk_sys);
            if (echo_win && !pw) nr++;
            pw = echo_win;
        end
        chk("s3_reach_acq2", nr, 2);
        repeat (5) @(posedge clk_sys);
        #1 seq_abort = 1'b1;
        tick(); seq_abort = 1'b0;
        @(negedge clk_sys);
        chk("s3_win", echo_win, 0); chk("s3_busy", busy, 0);
        chk("s3_ecnt", echo_cnt, 1); chk("s3_no_done", done_cnt - d0, 0);
        repeat (5) @(negedge clk_sys);

        // Bridge silent: timeout raises err TO cycles after the fire strobe.
        bri_en = 1'b0;
        exp_load.push_back({1'b0, 8'd2, 16'h1234});
        d0 = done_cnt;
        start_seq();
        for (int i = 0; i < 3 * TO; i++) begin
            @(negedge clk_sys);
            if (err) break;
        end
        chk("s4_err", err, 1); chk("s4_delay", cyc - fire_cyc, TO); chk("s4_busy", busy, 0);
        repeat (10) @(negedge clk_sys);
        chk("s4_err_hold", err, 1); chk("s4_no_done", done_cnt - d0, 0);

        // Reset mid-pulse; registers must come back at their defaults.
        bri_en = 1'b1;
        exp_load.push_back({1'b0, 8'd2, 16'h1234});
        start_seq(); @(negedge clk_sys);
        chk("s6_err_clr", err, 0); chk("s6_busy", busy, 1);
        for (int i = 0; i < 20; i++) begin
            if (state_start) break;
            @(negedge clk_sys);
        end
        chk("s6_fired", state_start, 1);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk_sys);
        chk_all_zero("s6");
        repeat (20) @(negedge clk_sys);
        start_seq(); @(negedge clk_sys); chk("s6_def_num", busy, 0);
        cfg_wr(2'd1, 16'd1);
        push_train(100, 1, 8'd4, 8'd8, 16'h0000);
        start_seq();
        wait_done(1500);
        chk("s6_ecnt", echo_cnt, 1);
        repeat (3) @(negedge clk_sys);

        chk("load_q_left", exp_load.size(), 0);
        chk("gap_q_left", exp_gap.size(), 0);
        chk("win_q_left", exp_win.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
